// File: rtl/player_input_pkg.sv
// player_input_pkg
//   Shared types and helpers for the player-input arbiter.
//   - state_e       : arbiter FSM states (IDLE / ARMED / LATCHED)
//   - MAX_PLAYERS   : width of the priority-encoder input vector
//   - DEF_NUM_PLAYERS, DEF_ID_W : default top-level sizing
//   - prio_enc()    : index of the lowest set bit (0 when none set)
package player_input_pkg;

    localparam int unsigned MAX_PLAYERS     = 4;
    localparam int unsigned DEF_NUM_PLAYERS = 4;
    localparam int unsigned DEF_ID_W        = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LATCHED = 2'd2
    } state_e;

    // Fixed priority: the lowest index wins among simultaneous presses.
    function automatic logic [1:0] prio_enc(input logic [MAX_PLAYERS-1:0] v);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PLAYERS; i++) begin
            if (v[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/player_input_arbiter_button_debounce.sv
// button_debounce
//   One raw button: 2-flop synchroniser, stability counter, rising-edge
//   detector. The debounced level flips after the synchronised level has
//   disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset
//   btn_i  : raw asynchronous button, active-high
//   db_o   : debounced level
//   edge_o : one-cycle pulse, high in the first cycle db_o is high
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic db_o,
    output logic edge_o
);

    logic        sync1_q, sync2_q;
    logic        db_q, db_d;
    logic [15:0] cnt_q, cnt_d;
    logic        edge_q, edge_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        // Edge computed from the next level so the pulse lines up with the
        // first cycle of the new debounced high.
        edge_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
        end
    end

    assign db_o   = db_q;
    assign edge_o = edge_q;

endmodule

// File: rtl/player_input_arbiter.sv
// player_input_arbiter
//   Debounces the player buttons and, while armed, latches the first player
//   to press. The sticky playerInputFlag feeds the data memory's player-input
//   flag word (address 37).
// Optional feature macro: PLAYER_INPUT_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYCLES and output timeout; an unanswered round
//   returns to IDLE after TIMEOUT_CYCLES cycles in ARMED.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   btn             : raw buttons, active-high
//   arm, clear      : one-cycle round open / close pulses
//   playerInputFlag : high while a winner is latched
//   player_id       : index of the latched winner (held through IDLE)
//   btn_db          : debounced button levels
//   press_edge      : one-cycle rising-edge pulses of btn_db
//   armed           : high in the ARMED state
//   timeout         : (optional) one-cycle pulse on round expiry
module player_input_arbiter
    import player_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = DEF_NUM_PLAYERS,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned ID_W            = DEF_ID_W
`ifdef PLAYER_INPUT_TIMEOUT_EN
    ,parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] btn,
    input  logic                   arm,
    input  logic                   clear,
    output logic                   playerInputFlag,
    output logic [ID_W-1:0]        player_id,
    output logic [NUM_PLAYERS-1:0] btn_db,
    output logic [NUM_PLAYERS-1:0] press_edge,
    output logic                   armed
`ifdef PLAYER_INPUT_TIMEOUT_EN
    ,output logic                  timeout
`endif
);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn[g]),
            .db_o   (btn_db[g]),
            .edge_o (press_edge[g])
        );
    end

    // Unused upper inputs stay zero, so the encoder never reports an index
    // at or above NUM_PLAYERS.
    logic [MAX_PLAYERS-1:0] pe_ext;
    always_comb begin
        pe_ext                  = '0;
        pe_ext[NUM_PLAYERS-1:0] = press_edge;
    end

    state_e          state_q;
    logic            flag_q;
    logic [ID_W-1:0] id_q;
    logic            armed_q;
`ifdef PLAYER_INPUT_TIMEOUT_EN
    logic [31:0]     tcnt_q;
    logic            timeout_q;
`endif

    // Priority within a cycle: clear > press_edge > (timeout) > arm.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            flag_q    <= 1'b0;
            id_q      <= '0;
            armed_q   <= 1'b0;
`ifdef PLAYER_INPUT_TIMEOUT_EN
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef PLAYER_INPUT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (arm && !clear) begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
`ifdef PLAYER_INPUT_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (clear) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (|pe_ext) begin
                        state_q <= S_LATCHED;
                        armed_q <= 1'b0;
                        flag_q  <= 1'b1;
                        id_q    <= ID_W'(prio_enc(pe_ext));
                    end
`ifdef PLAYER_INPUT_TIMEOUT_EN
                    else if (tcnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        state_q   <= S_IDLE;
                        armed_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
`endif
                end
                S_LATCHED: begin
                    if (clear) begin
                        state_q <= S_IDLE;
                        flag_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    flag_q  <= 1'b0;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign playerInputFlag = flag_q;
    assign player_id       = id_q;
    assign armed           = armed_q;
`ifdef PLAYER_INPUT_TIMEOUT_EN
    assign timeout         = timeout_q;
`endif

endmodule

// File: tb/tb_player_input_arbiter.sv
// tb_player_input_arbiter
//   Directed bench for player_input_arbiter with DEBOUNCE_CYCLES=4 (button
//   edge to btn_db/press_edge = 6 cycles). Timeout checks are compiled only
//   when PLAYER_INPUT_TIMEOUT_EN is defined.
module tb_player_input_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       arm, clear;
    logic       playerInputFlag;
    logic [1:0] player_id;
    logic [3:0] btn_db, press_edge;
    logic       armed;
`ifdef PLAYER_INPUT_TIMEOUT_EN
    logic       timeout;
`endif

    always #5 clk = ~clk;

    player_input_arbiter #(
        .NUM_PLAYERS(4),
        .DEBOUNCE_CYCLES(16'd4),
        .ID_W(2)
`ifdef PLAYER_INPUT_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(32'd10)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn             (btn),
        .arm             (arm),
        .clear           (clear),
        .playerInputFlag (playerInputFlag),
        .player_id       (player_id),
        .btn_db          (btn_db),
        .press_edge      (press_edge),
        .armed           (armed)
`ifdef PLAYER_INPUT_TIMEOUT_EN
        ,.timeout        (timeout)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       arm;
        logic       clr;
        int         hold;
        logic       flag;
        logic [1:0] id;
        logic       armed;
        logic [3:0] db;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int npulse, at;

        vecs[0]  = '{4'b0000, 1'b0, 1'b0,  2, 1'b0, 2'd0, 1'b0, 4'b0000}; // reset state
        vecs[1]  = '{4'b0000, 1'b1, 1'b0,  2, 1'b0, 2'd0, 1'b1, 4'b0000}; // arm
        vecs[2]  = '{4'b0100, 1'b0, 1'b0, 10, 1'b1, 2'd2, 1'b0, 4'b0100}; // p2 wins
        vecs[3]  = '{4'b0101, 1'b0, 1'b0, 10, 1'b1, 2'd2, 1'b0, 4'b0101}; // late p0 ignored
        vecs[4]  = '{4'b0101, 1'b0, 1'b1,  1, 1'b0, 2'd2, 1'b0, 4'b0101}; // clear: flag drops next cycle
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 10, 1'b0, 2'd2, 1'b0, 4'b0000};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0,  2, 1'b0, 2'd2, 1'b1, 4'b0000};
        vecs[7]  = '{4'b1010, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b0, 4'b1010}; // simultaneous p3/p1
        vecs[8]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b0, 2'd1, 1'b0, 4'b1010};
        vecs[9]  = '{4'b0000, 1'b0, 1'b0, 10, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[10] = '{4'b0001, 1'b0, 1'b0, 10, 1'b0, 2'd1, 1'b0, 4'b0001}; // press in IDLE
        vecs[11] = '{4'b0001, 1'b1, 1'b0,  3, 1'b0, 2'd1, 1'b1, 4'b0001}; // held through arm
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 10, 1'b0, 2'd1, 1'b1, 4'b0000}; // release: no latch
        vecs[13] = '{4'b0001, 1'b0, 1'b0, 10, 1'b1, 2'd0, 1'b0, 4'b0001}; // re-press latches
        vecs[14] = '{4'b0001, 1'b1, 1'b0,  2, 1'b1, 2'd0, 1'b0, 4'b0001}; // arm ignored in LATCHED
        vecs[15] = '{4'b0001, 1'b1, 1'b1,  2, 1'b0, 2'd0, 1'b0, 4'b0001}; // arm+clear -> IDLE
        vecs[16] = '{4'b0001, 1'b1, 1'b0,  2, 1'b0, 2'd0, 1'b1, 4'b0001};
        vecs[17] = '{4'b0001, 1'b1, 1'b0,  2, 1'b0, 2'd0, 1'b1, 4'b0001}; // re-arm: no effect
        vecs[18] = '{4'b0001, 1'b1, 1'b1,  2, 1'b0, 2'd0, 1'b0, 4'b0001}; // arm+clear in ARMED
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b0, 4'b0000};

        rst = 1'b0; btn = '0; arm = 1'b0; clear = 1'b0;
        tick(3);
        chk("reset_edge", 32'(press_edge), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            btn = vecs[i].btn; arm = vecs[i].arm; clear = vecs[i].clr;
            tick(1);
            arm = 1'b0; clear = 1'b0;
            tick(vecs[i].hold - 1);
            chk($sformatf("v%0d_flag", i),  32'(playerInputFlag), 32'(vecs[i].flag));
            chk($sformatf("v%0d_id", i),    32'(player_id),       32'(vecs[i].id));
            chk($sformatf("v%0d_armed", i), 32'(armed),           32'(vecs[i].armed));
            chk($sformatf("v%0d_db", i),    32'(btn_db),          32'(vecs[i].db));
        end

        // Press edge coinciding with clear while ARMED: no latch.
        arm = 1'b1; tick(1); arm = 1'b0; tick(1);
        btn = 4'b0100;
        tick(6);
        chk("pc_edge", 32'(press_edge), 32'h4);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("pc_flag",  32'(playerInputFlag), 32'h0);
        chk("pc_armed", 32'(armed),           32'h0);
        chk("pc_id",    32'(player_id),       32'h0);
        btn = '0; tick(10);

        // Bouncing btn[1]: two-cycle high/low bursts never survive debounce.
        npulse = 0; at = -1;
        for (int c = 0; c < 20; c++) begin
            btn[1] = ((c / 2) % 2) == 0;
            tick(1);
            if (press_edge[1]) npulse++;
        end
        btn[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (press_edge[1]) begin npulse++; at = k; end
        end
        chk("bounce_pulses",  32'(npulse),    32'd1);
        chk("bounce_latency", 32'(at),        32'd6);
        chk("bounce_db",      32'(btn_db[1]), 32'd1);
        btn = '0; tick(10);

        // Reset asserted mid-round with the flag high.
        arm = 1'b1; tick(1); arm = 1'b0;
        btn = 4'b0100; tick(10);
        chk("mr_flag_pre", 32'(playerInputFlag), 32'h1);
        rst = 1'b0; tick(1);
        chk("mr_flag",  32'(playerInputFlag), 32'h0);
        chk("mr_armed", 32'(armed),           32'h0);
        chk("mr_id",    32'(player_id),       32'h0);
        chk("mr_db",    32'(btn_db),          32'h0);
        rst = 1'b1; btn = '0; tick(10);
        chk("mr_idle_flag", 32'(playerInputFlag), 32'h0);

`ifdef PLAYER_INPUT_TIMEOUT_EN
        // Unanswered round expires 10 cycles after entering ARMED.
        npulse = 0; at = -1;
        arm = 1'b1; tick(1); arm = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            tick(1);
            if (timeout) begin npulse++; at = k; end
        end
        chk("to_pulses", 32'(npulse),          32'd1);
        chk("to_at",     32'(at),              32'd11);
        chk("to_armed",  32'(armed),           32'h0);
        chk("to_flag",   32'(playerInputFlag), 32'h0);

        // Press edge arriving in the expiry cycle wins.
        npulse = 0;
        arm = 1'b1; tick(1); arm = 1'b0;
        tick(3);
        btn = 4'b1000;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (timeout) npulse++;
        end
        chk("toc_pulses", 32'(npulse),          32'd0);
        chk("toc_flag",   32'(playerInputFlag), 32'h1);
        chk("toc_id",     32'(player_id),       32'h3);
        clear = 1'b1; tick(1); clear = 1'b0;
        btn = '0; tick(10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
